// File: rtl/bombe_pkg.sv
// Shared constants and state encoding for the bombe rotor stepper slice.
package bombe_pkg;

    localparam int ALPHABET_SIZE = 26;
    localparam int POS_W         = 5;
    localparam int CNT_W         = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } stepper_state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the slow tick from the rate divider.
// Define STEPPER_TICK_SYNC_EN for the 2-flop synchroniser (hardware builds).
module tick_edge_detect (
    input  logic clk_in,
    input  logic resetn,
    input  logic tick_in,
    output logic step_en
);

    logic tick_s;
    logic tick_prev;

`ifdef STEPPER_TICK_SYNC_EN
    logic tick_meta;

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            tick_meta <= 1'b0;
            tick_s    <= 1'b0;
        end else begin
            tick_meta <= tick_in;
            tick_s    <= tick_meta;
        end
    end
`else
    // Single capture flop only; metastability is not handled in this build.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            tick_s <= 1'b0;
        end else begin
            tick_s <= tick_in;
        end
    end
`endif

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= tick_s;
        end
    end

    assign step_en = tick_s & ~tick_prev;

endmodule

// File: rtl/bombe_rotor_stepper.sv
// Three-rotor odometer advanced by slow-tick edges, with run/pause/load control.
// Tick synchroniser depth is selected by STEPPER_TICK_SYNC_EN (see tick_edge_detect).
module bombe_rotor_stepper #(
    parameter int NUM_POS = bombe_pkg::ALPHABET_SIZE,
    parameter int POS_W   = bombe_pkg::POS_W,
    parameter int CNT_W   = bombe_pkg::CNT_W
) (
    input  logic                 clk_in,
    input  logic                 resetn,
    input  logic                 tick_in,
    input  logic                 start,
    input  logic                 stop_req,
    input  logic                 load,
    input  logic [3*POS_W-1:0]   load_pos,
    output logic [POS_W-1:0]     rotor_l,
    output logic [POS_W-1:0]     rotor_m,
    output logic [POS_W-1:0]     rotor_r,
    output logic                 step_pulse,
    output logic                 busy,
    output logic                 done
);

    import bombe_pkg::*;

    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(NUM_POS - 1);
    localparam logic [POS_W-1:0] POS_LIMIT = POS_W'(NUM_POS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_POS * NUM_POS * NUM_POS - 1);

    stepper_state_t   state;
    logic [CNT_W-1:0] step_cnt;
    logic             step_en;
    logic [POS_W-1:0] raw_l, raw_m, raw_r;
    logic [POS_W-1:0] ld_l, ld_m, ld_r;

    tick_edge_detect u_tick_edge (
        .clk_in  (clk_in),
        .resetn  (resetn),
        .tick_in (tick_in),
        .step_en (step_en)
    );

    assign raw_l = load_pos[3*POS_W-1 -: POS_W];
    assign raw_m = load_pos[2*POS_W-1 -: POS_W];
    assign raw_r = load_pos[POS_W-1:0];

    // Out-of-range load values would never be reached by stepping, so force them to 0.
    assign ld_l = (raw_l >= POS_LIMIT) ? '0 : raw_l;
    assign ld_m = (raw_m >= POS_LIMIT) ? '0 : raw_m;
    assign ld_r = (raw_r >= POS_LIMIT) ? '0 : raw_r;

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rotor_l    <= '0;
            rotor_m    <= '0;
            rotor_r    <= '0;
            step_cnt   <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                RUN: begin
                    // stop_req wins over a coincident edge, which is then lost.
                    if (stop_req) begin
                        state <= PAUSE;
                    end else if (step_en) begin
                        step_pulse <= 1'b1;
                        step_cnt   <= step_cnt + CNT_W'(1);
                        if (rotor_r == LAST_POS) begin
                            rotor_r <= '0;
                            if (rotor_m == LAST_POS) begin
                                rotor_m <= '0;
                                rotor_l <= (rotor_l == LAST_POS) ? '0 : rotor_l + POS_W'(1);
                            end else begin
                                rotor_m <= rotor_m + POS_W'(1);
                            end
                        end else begin
                            rotor_r <= rotor_r + POS_W'(1);
                        end
                        if (step_cnt == LAST_CNT) begin
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    if (load) begin
                        rotor_l  <= ld_l;
                        rotor_m  <= ld_m;
                        rotor_r  <= ld_r;
                        step_cnt <= '0;
                    end
                    if (start && !stop_req) begin
                        state <= RUN;
                        if (state == DONE) begin
                            step_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// Self-checking bench for bombe_rotor_stepper: step vectors, carry, pause, reset, full sweep.
module tb_bombe_rotor_stepper;

    localparam int NP    = 26;
    localparam int TOTAL = NP * NP * NP;
`ifdef STEPPER_TICK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk_in = 1'b0;
    logic        resetn;
    logic        tick_in;
    logic        start;
    logic        stop_req;
    logic        load;
    logic [14:0] load_pos;
    logic [4:0]  rotor_l, rotor_m, rotor_r;
    logic        step_pulse, busy, done;

    typedef struct {
        int l;
        int m;
        int r;
    } pos_t;

    typedef struct {
        int ld_l, ld_m, ld_r;
        int ex_l, ex_m, ex_r;
    } vec_t;

    pos_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   model_idx = 0;

    bombe_rotor_stepper dut (
        .clk_in     (clk_in),
        .resetn     (resetn),
        .tick_in    (tick_in),
        .start      (start),
        .stop_req   (stop_req),
        .load       (load),
        .load_pos   (load_pos),
        .rotor_l    (rotor_l),
        .rotor_m    (rotor_m),
        .rotor_r    (rotor_r),
        .step_pulse (step_pulse),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_in = ~clk_in;

    function automatic pos_t idx_to_pos(input int idx);
        pos_t p;
        p.l = idx / (NP * NP);
        p.m = (idx / NP) % NP;
        p.r = idx % NP;
        return p;
    endfunction

    function automatic int clamp(input int v);
        return (v >= NP) ? 0 : v;
    endfunction

    function automatic pos_t mk(input int l, input int m, input int r);
        pos_t p;
        p.l = l;
        p.m = m;
        p.r = r;
        return p;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic check_rotors(input string name, input pos_t e);
        check_output({name, "_l"}, 32'(rotor_l), e.l);
        check_output({name, "_m"}, 32'(rotor_m), e.m);
        check_output({name, "_r"}, 32'(rotor_r), e.r);
    endtask

    // Every step_pulse consumes one expected position pushed when the tick was driven.
    always @(negedge clk_in) begin
        pos_t e;
        if (resetn === 1'b1 && step_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_step actual=%0d/%0d/%0d expected=no_step",
                         rotor_l, rotor_m, rotor_r);
            end else begin
                e = sb.pop_front();
                check_rotors("sb_step", e);
            end
        end
    end

    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_tick(input bit expect_step);
        if (expect_step) begin
            model_idx = (model_idx + 1) % TOTAL;
            sb.push_back(idx_to_pos(model_idx));
        end
        tick_in = 1'b1;
        tick_clk(1);
        tick_in = 1'b0;
        tick_clk(1);
    endtask

    task automatic do_load(input int l, input int m, input int r);
        load_pos = {5'(l), 5'(m), 5'(r)};
        load     = 1'b1;
        tick_clk(1);
        load     = 1'b0;
        model_idx = clamp(l) * NP * NP + clamp(m) * NP + clamp(r);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick_clk(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop_req = 1'b1;
        tick_clk(1);
        stop_req = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        int lat;
        bit seen;
        do_stop();
        do_load(v.ld_l, v.ld_m, v.ld_r);
        check_rotors("vec_load", mk(clamp(v.ld_l), clamp(v.ld_m), clamp(v.ld_r)));
        do_start();
        check_output("vec_busy", 32'(busy), 1);
        model_idx = (model_idx + 1) % TOTAL;
        sb.push_back(idx_to_pos(model_idx));
        tick_in = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            tick_clk(1);
            if (step_pulse === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check_output("vec_latency", lat, LAT);
        check_rotors("vec_step", mk(v.ex_l, v.ex_m, v.ex_r));
        tick_in = 1'b0;
        tick_clk(2);
        check_output("vec_pulse_width", 32'(step_pulse), 0);
        check_output("vec_sb_drain", sb.size(), 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{ld_l: 0,  ld_m: 0,  ld_r: 24, ex_l: 0,  ex_m: 0, ex_r: 25};
        vecs[1] = '{ld_l: 4,  ld_m: 25, ld_r: 25, ex_l: 5,  ex_m: 0, ex_r: 0};
        vecs[2] = '{ld_l: 25, ld_m: 25, ld_r: 25, ex_l: 0,  ex_m: 0, ex_r: 0};
        vecs[3] = '{ld_l: 3,  ld_m: 7,  ld_r: 25, ex_l: 3,  ex_m: 8, ex_r: 0};
        vecs[4] = '{ld_l: 30, ld_m: 2,  ld_r: 5,  ex_l: 0,  ex_m: 2, ex_r: 6};
        vecs[5] = '{ld_l: 12, ld_m: 31, ld_r: 25, ex_l: 12, ex_m: 1, ex_r: 0};

        resetn   = 1'b0;
        tick_in  = 1'b0;
        start    = 1'b0;
        stop_req = 1'b0;
        load     = 1'b0;
        load_pos = '0;
        tick_clk(3);
        check_rotors("reset", mk(0, 0, 0));
        check_output("reset_pulse", 32'(step_pulse), 0);
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_done", 32'(done), 0);
        resetn = 1'b1;
        tick_clk(2);

        // IDLE discards edges
        do_tick(1'b0);
        tick_clk(LAT);
        check_rotors("idle_tick", mk(0, 0, 0));

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i]);
        end

        // load while running is ignored
        load_pos = {5'd9, 5'd9, 5'd9};
        load     = 1'b1;
        tick_clk(1);
        load     = 1'b0;
        check_rotors("run_load", mk(12, 1, 0));
        do_tick(1'b1);
        tick_clk(LAT);
        check_rotors("run_load_step", mk(12, 1, 1));

        // stop_req coincident with the step edge
        tick_in = 1'b1;
        tick_clk(LAT - 1);
        stop_req = 1'b1;
        tick_clk(1);
        stop_req = 1'b0;
        tick_in  = 1'b0;
        tick_clk(3);
        check_output("pause_busy", 32'(busy), 0);
        check_rotors("pause_hold", mk(12, 1, 1));
        do_tick(1'b0);
        do_tick(1'b0);
        tick_clk(LAT);
        check_rotors("pause_ignore", mk(12, 1, 1));
        start    = 1'b1;
        stop_req = 1'b1;
        tick_clk(1);
        start    = 1'b0;
        stop_req = 1'b0;
        check_output("pause_start_stop", 32'(busy), 0);
        do_start();
        check_output("resume_busy", 32'(busy), 1);
        do_tick(1'b1);
        tick_clk(LAT);
        check_rotors("resume_step", mk(12, 1, 2));
        start    = 1'b1;
        stop_req = 1'b1;
        tick_clk(1);
        start    = 1'b0;
        stop_req = 1'b0;
        check_output("run_start_stop", 32'(busy), 0);

        // reset while a step is pending
        do_load(3, 7, 25);
        do_start();
        tick_in = 1'b1;
        tick_clk(LAT - 1);
        resetn = 1'b0;
        #1;
        check_rotors("midrun_reset", mk(0, 0, 0));
        check_output("midrun_reset_busy", 32'(busy), 0);
        check_output("midrun_reset_pulse", 32'(step_pulse), 0);
        check_output("midrun_reset_done", 32'(done), 0);
        tick_in = 1'b0;
        tick_clk(2);
        resetn = 1'b1;
        tick_clk(1);
        model_idx = 0;
        do_tick(1'b0);
        tick_clk(LAT);
        check_rotors("post_reset_idle", mk(0, 0, 0));
        check_output("post_reset_busy", 32'(busy), 0);

        // full sweep of every position
        do_load(1, 2, 3);
        do_start();
        for (int k = 0; k < TOTAL; k++) begin
            if (k == TOTAL - 1) begin
                tick_clk(LAT);
                check_output("sweep_pre_done", 32'(done), 0);
                check_output("sweep_pre_busy", 32'(busy), 1);
            end
            do_tick(1'b1);
        end
        tick_clk(LAT + 1);
        check_output("sweep_done", 32'(done), 1);
        check_output("sweep_busy", 32'(busy), 0);
        check_rotors("sweep_end", mk(1, 2, 3));
        check_output("sweep_sb_drain", sb.size(), 0);
        do_tick(1'b0);
        tick_clk(LAT);
        check_rotors("done_ignore", mk(1, 2, 3));
        check_output("done_hold", 32'(done), 1);
        do_start();
        check_output("restart_done", 32'(done), 0);
        check_output("restart_busy", 32'(busy), 1);
        do_tick(1'b1);
        tick_clk(LAT);
        check_rotors("restart_step", mk(1, 2, 4));
        tick_clk(2);
        check_output("final_sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
